dcache_port_arbiter: RTL and testbench

- Shares one dcache controller request port between NR_PORTS core-side requesters (load unit, store unit, PTW, ...).
- Arbitration is round-robin. The selected request is held stable until the cache grants it.
- Granted read IDs are tracked in order, so each returned rvalid/rdata is routed to its originating port.
- Sits between the core request interfaces and the cache_ctrl request input.

---
 rtl/dcache_port_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: round-robin sharing of one cache_ctrl request port
// between NR_PORTS core-side requesters. The presented request is locked
// until the cache grants it. Granted reads are remembered in grant order so
// each cache response is steered back to the port that issued it.
// Optional feature: define DCACHE_ARB_PERF_EN to add per-port saturating
// stall counters on stall_cnt_o.
module dcache_port_arbiter #(
  parameter int NR_PORTS  = 4,
  parameter int ADDR_W    = 56,
  parameter int DATA_W    = 64,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_PORTS-1:0]          req_i,
  input  logic [NR_PORTS-1:0]          we_i,
  input  logic [NR_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NR_PORTS*DATA_W-1:0]   wdata_i,
  output logic [NR_PORTS-1:0]          gnt_o,
  output logic [NR_PORTS-1:0]          rvalid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         cache_req_o,
  output logic                         cache_we_o,
  output logic [ADDR_W-1:0]            cache_addr_o,
  output logic [DATA_W-1:0]            cache_wdata_o,
  input  logic                         cache_gnt_i,
  input  logic                         cache_rvalid_i,
  input  logic [DATA_W-1:0]            cache_rdata_i,
  output logic                         outst_full_o,
  output logic                         err_o
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [NR_PORTS*16-1:0]       stall_cnt_o
`endif
);

  localparam int PW = $clog2(NR_PORTS);
  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [PW-1:0]       ptr_r;
  logic [PW-1:0]       lock_idx_r;
  logic [PW-1:0]       fifo_r [MAX_OUTST];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       cnt_r;
  logic                err_r;

  logic                full_s;
  logic [NR_PORTS-1:0] elig_s;
  logic                found_s;
  logic [PW-1:0]       pick_s;
  logic [PW-1:0]       sel_s;
  logic                req_s;
  logic                grant_s;
  logic                push_s;
  logic                pop_s;
  logic [PW-1:0]       head_s;

  // Select the port to present: latched port when locked, else first eligible from the RR pointer.
  always_comb begin
    full_s  = (cnt_r == CW'(MAX_OUTST));
    elig_s  = req_i & (we_i | {NR_PORTS{~full_s}});
    found_s = 1'b0;
    pick_s  = {PW{1'b0}};
    for (int k = 0; k < NR_PORTS; k++) begin
      int idx_v;
      logic hit_v;
      idx_v = int'(ptr_r) + k;
      if (idx_v >= NR_PORTS) begin
        idx_v = idx_v - NR_PORTS;
      end else begin
        idx_v = idx_v;
      end
      hit_v   = elig_s[idx_v] & ~found_s;
      pick_s  = hit_v ? PW'(idx_v) : pick_s;
      found_s = found_s | hit_v;
    end
    if (state_r == LOCKED) begin
      sel_s = lock_idx_r;
      req_s = rst_ni;
    end else begin
      sel_s = pick_s;
      req_s = found_s & rst_ni;
    end
    grant_s = req_s & cache_gnt_i;
    push_s  = grant_s & ~we_i[sel_s];
    pop_s   = cache_rvalid_i & (cnt_r != {CW{1'b0}});
    head_s  = fifo_r[rd_ptr_r];
  end

  // Next-state logic: a presented but ungranted request locks the arbiter.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s & ~cache_gnt_i) begin
          state_s = LOCKED;
        end else begin
          state_s = IDLE;
        end
      end
      LOCKED: begin
        if (cache_gnt_i) begin
          state_s = IDLE;
        end else begin
          state_s = LOCKED;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output muxing toward the cache and per-port grant / response steering.
  always_comb begin
    cache_req_o   = req_s;
    cache_we_o    = req_s & we_i[sel_s];
    cache_addr_o  = req_s ? addr_i[int'(sel_s)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
    cache_wdata_o = req_s ? wdata_i[int'(sel_s)*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    for (int i = 0; i < NR_PORTS; i++) begin
      gnt_o[i]    = grant_s & (sel_s == PW'(i));
      rvalid_o[i] = pop_s & (head_s == PW'(i));
    end
    rdata_o      = pop_s ? cache_rdata_i : {DATA_W{1'b0}};
    outst_full_o = full_s;
    err_o        = err_r;
  end

  // Arbiter state, locked index and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      lock_idx_r <= {PW{1'b0}};
      ptr_r      <= {PW{1'b0}};
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && req_s && !cache_gnt_i) begin
        lock_idx_r <= sel_s;
      end else begin
        lock_idx_r <= lock_idx_r;
      end
      if (grant_s) begin
        ptr_r <= (sel_s == PW'(NR_PORTS - 1)) ? {PW{1'b0}} : sel_s + PW'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // In-order tracking of granted reads; push and pop may happen together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        fifo_r[i] <= {PW{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (cache_rvalid_i & (cnt_r == {CW{1'b0}}));
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [NR_PORTS*16-1:0] stall_r;

  // Per-port saturating count of cycles spent requesting without a grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r <= {(NR_PORTS*16){1'b0}};
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        if (req_i[i] && !gnt_o[i] && (stall_r[i*16 +: 16] != 16'hFFFF)) begin
          stall_r[i*16 +: 16] <= stall_r[i*16 +: 16] + 16'd1;
        end else begin
          stall_r[i*16 +: 16] <= stall_r[i*16 +: 16];
        end
      end
    end
  end

  assign stall_cnt_o = stall_r;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: a driver applies directed and
// random stimulus and a queue-based reference model pushes expectations;
// a monitor pops and compares against what the DUT presents.
module tb_dcache_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 56;
  localparam int DW = 64;
  localparam int MO = 4;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_i = '0, we_i = '0;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]   rdata_o;
  logic            cache_req_o, cache_we_o;
  logic [AW-1:0]   cache_addr_o;
  logic [DW-1:0]   cache_wdata_o;
  logic            cache_gnt_i = 1'b0, cache_rvalid_i = 1'b0;
  logic [DW-1:0]   cache_rdata_i = '0;
  logic            outst_full_o, err_o;
`ifdef DCACHE_ARB_PERF_EN
  logic [N*16-1:0] stall_cnt_o;
`endif

  dcache_port_arbiter #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .cache_req_o(cache_req_o), .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o),
    .cache_wdata_o(cache_wdata_o), .cache_gnt_i(cache_gnt_i),
    .cache_rvalid_i(cache_rvalid_i), .cache_rdata_i(cache_rdata_i),
    .outst_full_o(outst_full_o), .err_o(err_o)
`ifdef DCACHE_ARB_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          full;
    logic          err;
    logic [63:0]   stall;
  } status_t;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } resp_t;

  status_t st_q[$];
  int      gnt_q[$];
  resp_t   rv_q[$];

  // reference model state
  int      outst_m[$];
  int      ptr_m = 0;
  int      lock_m = -1;
  bit      err_m = 1'b0;
  int      stall_m[N];
  int      last_gnt = -1;

  logic [AW-1:0] addr_a[N];
  logic [DW-1:0] wdata_a[N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock cycle with the inputs already applied.
  task automatic model_cycle();
    status_t s;
    int sel;
    int size0;
    resp_t r;
    last_gnt = -1;
    s.req = 1'b0; s.we = 1'b0; s.addr = '0; s.wdata = '0;
    s.full = 1'b0; s.err = 1'b0; s.stall = '0;
    if (!rst_ni) begin
      ptr_m = 0; lock_m = -1; err_m = 1'b0;
      outst_m.delete();
      for (int i = 0; i < N; i++) stall_m[i] = 0;
      st_q.push_back(s);
      return;
    end
    size0 = outst_m.size();
    s.full = (size0 == MO);
    s.err  = err_m;
    for (int i = 0; i < N; i++) s.stall[i*16 +: 16] = 16'(stall_m[i]);
    sel = -1;
    if (lock_m >= 0) begin
      sel = lock_m;
    end else begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (ptr_m + k) % N;
        if (sel < 0 && req_i[p] && (we_i[p] || size0 < MO)) sel = p;
      end
    end
    if (sel >= 0) begin
      s.req = 1'b1; s.we = we_i[sel]; s.addr = addr_a[sel]; s.wdata = wdata_a[sel];
    end
    st_q.push_back(s);
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !(sel == i && cache_gnt_i) && stall_m[i] < 65535) stall_m[i]++;
    end
    if (cache_rvalid_i) begin
      if (size0 == 0) begin
        err_m = 1'b1;
      end else begin
        r.port = outst_m.pop_front();
        r.data = cache_rdata_i;
        rv_q.push_back(r);
      end
    end
    if (sel >= 0) begin
      if (cache_gnt_i) begin
        gnt_q.push_back(sel);
        last_gnt = sel;
        ptr_m = (sel + 1) % N;
        lock_m = -1;
        if (!we_i[sel]) outst_m.push_back(sel);
      end else begin
        lock_m = sel;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N-1:0] w, input logic g,
                      input logic rv, input logic [DW-1:0] rd, input logic rs);
    @(negedge clk);
    rst_ni = rs; req_i = rq; we_i = w;
    for (int i = 0; i < N; i++) begin
      addr_i[i*AW +: AW]  = addr_a[i];
      wdata_i[i*DW +: DW] = wdata_a[i];
    end
    cache_gnt_i = g; cache_rvalid_i = rv; cache_rdata_i = rd;
    #2;
    model_cycle();
  endtask

  // Monitor: compares DUT outputs with the expectations queued for this cycle.
  initial begin
    status_t s;
    resp_t r;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("cache_req", 64'(cache_req_o), 64'(s.req));
        if (s.req) begin
          chk("cache_we", 64'(cache_we_o), 64'(s.we));
          chk("cache_addr", 64'(cache_addr_o), 64'(s.addr));
          chk("cache_wdata", cache_wdata_o, s.wdata);
        end
        chk("outst_full", 64'(outst_full_o), 64'(s.full));
        chk("err", 64'(err_o), 64'(s.err));
`ifdef DCACHE_ARB_PERF_EN
        chk("stall_cnt", stall_cnt_o, s.stall);
`endif
      end
      if (gnt_o != '0 || gnt_q.size() > 0) begin
        e = '0;
        if (gnt_q.size() > 0) e = 64'd1 << gnt_q.pop_front();
        chk("gnt", 64'(gnt_o), e);
      end
      if (rvalid_o != '0 || rv_q.size() > 0) begin
        if (rv_q.size() > 0) begin
          r = rv_q.pop_front();
          e = 64'd1 << r.port;
          chk("rvalid", 64'(rvalid_o), e);
          chk("rdata", rdata_o, r.data);
        end else begin
          chk("rvalid_unexpected", 64'(rvalid_o), 64'd0);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] pend_v, pw_v;
    logic rv;
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = 56'({$urandom, $urandom});
      wdata_a[i] = {$urandom, $urandom};
      stall_m[i] = 0;
    end

    // reset values, including with busy inputs held during reset
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_addr", 64'(cache_addr_o), 64'd0);
    chk("rst_wdata", cache_wdata_o, 64'd0);
    step(4'b1111, 4'b0000, 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_req", 64'(cache_req_o), 64'd0);
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_rdata_busy", rdata_o, 64'd0);

    // round-robin fairness with writes and an always-granting cache
    repeat (5) step(4'b1111, 4'b1111, 1'b1, 1'b0, 64'h0, 1'b1);

    // lock hold: port2 waits three cycles while port0 also requests
    step(4'b0100, 4'b0100, 1'b0, 1'b0, 64'h0, 1'b1);
    step(4'b0101, 4'b0101, 1'b0, 1'b0, 64'h0, 1'b1);
    step(4'b0101, 4'b0101, 1'b0, 1'b0, 64'h0, 1'b1);
    chk("lock_addr", 64'(cache_addr_o), 64'(addr_a[2]));
    step(4'b0101, 4'b0101, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 64'h0, 1'b1);

    // in-order routing: reads from ports 1, 3, 0
    step(4'b0010, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b1000, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 64'hAAAA_0000_0000_000A, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 64'hBBBB_0000_0000_000B, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 64'hCCCC_0000_0000_000C, 1'b1);

    // FIFO full: reads blocked, writes pass, pop does not unblock same cycle
    step(4'b0001, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0010, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0100, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b1000, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0110, 4'b0100, 1'b1, 1'b0, 64'h0, 1'b1);
    step(4'b0010, 4'b0000, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
    step(4'b0010, 4'b0000, 1'b1, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, 1'b0, 1'b1, {$urandom, $urandom}, 1'b1);

    // spurious response sets a sticky error
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b1);

    // reset mid-lock, then an in-flight response after reset
    step(4'b0100, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b1);
    step(4'b0100, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("midrst_req", 64'(cache_req_o), 64'd0);
    chk("midrst_addr", 64'(cache_addr_o), 64'd0);
    chk("midrst_err", 64'(err_o), 64'd0);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 64'h77, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b1);

    // port1 waits five cycles before its grant
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b0);
    repeat (5) step(4'b0010, 4'b0010, 1'b0, 1'b0, 64'h0, 1'b1);
    step(4'b0010, 4'b0010, 1'b1, 1'b0, 64'h0, 1'b1);
`ifdef DCACHE_ARB_PERF_EN
    chk("stall_port1", 64'(stall_cnt_o[31:16]), 64'd5);
`endif

    // randomized traffic with requesters that hold until granted
    pend_v = '0; pw_v = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 99) < 35) begin
          pend_v[i]  = 1'b1;
          pw_v[i]    = 1'($urandom_range(0, 1));
          addr_a[i]  = 56'({$urandom, $urandom});
          wdata_a[i] = {$urandom, $urandom};
        end
      end
      rv = (outst_m.size() > 0) && ($urandom_range(0, 99) < 45);
      step(pend_v, pw_v, 1'($urandom_range(0, 99) < 65), rv, {$urandom, $urandom}, 1'b1);
      if (last_gnt >= 0) pend_v[last_gnt] = 1'b0;
    end

    step(4'b0000, 4'b0000, 1'b0, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    #5;
    chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    chk("rv_queue_drained", 64'(rv_q.size()), 64'd0);
    chk("status_queue_drained", 64'(st_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
